rs_encode_multimode_out_ctrl: RTL and testbench

Parametrised output controller for the Reed-Solomon stream encoder, sitting between the line encoder and the destination response stream. For each request it forwards data lines and discards pad lines. It then emits parity, either interleaved (each block's parity lines right after that block's data) or deferred (all parity buffered, then emitted after the last block's data). Block size, parity size, block count and line width are parameters, and counters and parity storage are internal.

---
 rtl/rs_encode_pkg.sv | 26 ++
 rtl/rs_parity_buf.sv | 29 ++
 rtl/rs_encode_multimode_out_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_rs_encode_multimode_out_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_encode_pkg.sv
// Shared types and width helpers for the Reed-Solomon stream encoder
// output path.
package rs_encode_pkg;

   typedef enum logic [2:0] {
      ST_READY,
      ST_DATA,
      ST_PAD,
      ST_PARITY_IN,
      ST_DRAIN
   } state_t;

   typedef enum logic {
      DEFERRED   = 1'b0,
      INTERLEAVE = 1'b1
   } mode_t;

   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

   function automatic int addr_w(input int blocks, input int par);
      return (blocks * par > 1) ? $clog2(blocks * par) : 1;
   endfunction

endpackage

// File: rtl/rs_parity_buf.sv
// Simple dual-port parity store, one write and one registered read
// per cycle.
module rs_parity_buf #(
   parameter int DEPTH = 32,
   parameter int WIDTH = 256,
   parameter int AW    = 5
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rd_en)
         rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/rs_encode_multimode_out_ctrl.sv
// Output controller: forwards data, drops pad, and emits parity either
// interleaved per block or deferred to the end of the request.
module rs_encode_multimode_out_ctrl
   import rs_encode_pkg::*;
#(
   parameter int DATA_W       = 256,
   parameter int MAX_BLOCKS   = 16,
   parameter int DATA_LINES   = 8,
   parameter int PARITY_LINES = 2,
   localparam int BLK_W  = cnt_w(MAX_BLOCKS),
   localparam int LINE_W = cnt_w(DATA_LINES),
   localparam int ADDR_W = addr_w(MAX_BLOCKS, PARITY_LINES)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_val,
   output logic              req_rdy,
   input  logic [BLK_W-1:0]  req_num_blocks,
   input  logic [LINE_W-1:0] req_last_data_lines,
   input  logic              req_interleave,
   input  logic              enc_val,
   output logic              enc_rdy,
   input  logic [DATA_W-1:0] enc_data,
   output logic              out_val,
   input  logic              out_rdy,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy
);

   localparam int PAR_W = cnt_w(PARITY_LINES);
   localparam int DEPTH = MAX_BLOCKS * PARITY_LINES;

   state_t              st;
   mode_t               mode;
   logic [BLK_W-1:0]    num_blocks;
   logic [LINE_W-1:0]   last_lines;
   logic [LINE_W-1:0]   line_cnt;
   logic [BLK_W-1:0]    blk_cnt;
   logic [PAR_W-1:0]    par_cnt;
   // one spare bit so a full buffer's end address does not alias 0
   logic [ADDR_W:0]     wr_addr;
   logic [ADDR_W:0]     rd_addr;

   logic [DATA_W-1:0]   sk_mem [2];
   logic                sk_wp;
   logic                sk_rp;
   logic [1:0]          sk_cnt;
   logic                rd_inflight;
   logic [DATA_W-1:0]   rd_data;

   logic                blk_last;
   logic [LINE_W-1:0]   data_lim;
   logic                par_last;
   logic                enc_acc;
   logic                wr_en;
   logic                rd_en;
   logic [2:0]          occ;
   logic                pop;
   logic                sk_pop;
   logic                push;
   logic                drain_end;

   assign blk_last = blk_cnt == num_blocks - BLK_W'(1);
   assign data_lim = blk_last ? last_lines : LINE_W'(DATA_LINES);
   assign par_last = par_cnt == PAR_W'(PARITY_LINES - 1);
   assign enc_acc  = enc_val && enc_rdy;
   assign wr_en    = st == ST_PARITY_IN && mode == DEFERRED && enc_val;

   assign occ    = {1'b0, sk_cnt} + {2'b0, rd_inflight};
   assign pop    = st == ST_DRAIN && out_val && out_rdy;
   assign sk_pop = pop && sk_cnt != 2'd0;
   // the RAM output falls through when the skid buffer is empty
   assign push   = rd_inflight && !(sk_cnt == 2'd0 && pop);
   assign rd_en  = st == ST_DRAIN && rd_addr != wr_addr &&
                   occ < 3'd2 + {2'b0, pop};
   assign drain_end = pop && rd_addr == wr_addr && occ == 3'd1;

   always_comb begin
      req_rdy  = st == ST_READY;
      busy     = st != ST_READY;
      enc_rdy  = 1'b0;
      out_val  = 1'b0;
      out_data = '0;
      out_last = 1'b0;
      unique case (st)
         ST_DATA: begin
            enc_rdy  = out_rdy;
            out_val  = enc_val;
            out_data = enc_data;
         end
         ST_PAD: enc_rdy = 1'b1;
         ST_PARITY_IN: begin
            if (mode == INTERLEAVE) begin
               enc_rdy  = out_rdy;
               out_val  = enc_val;
               out_data = enc_data;
               out_last = enc_val && blk_last && par_last;
            end else begin
               enc_rdy = 1'b1;
            end
         end
         ST_DRAIN: begin
            out_val  = occ != 3'd0;
            out_data = (sk_cnt != 2'd0) ? sk_mem[sk_rp] : rd_data;
            out_last = rd_addr == wr_addr && occ == 3'd1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         st         <= ST_READY;
         mode       <= DEFERRED;
         num_blocks <= '0;
         last_lines <= '0;
         line_cnt   <= '0;
         blk_cnt    <= '0;
         par_cnt    <= '0;
         wr_addr    <= '0;
         rd_addr    <= '0;
      end else begin
         unique case (st)
            ST_READY: begin
               if (req_val) begin
                  st         <= ST_DATA;
                  mode       <= mode_t'(req_interleave);
                  num_blocks <= req_num_blocks;
                  last_lines <= req_last_data_lines;
                  line_cnt   <= '0;
                  blk_cnt    <= '0;
                  par_cnt    <= '0;
                  wr_addr    <= '0;
                  rd_addr    <= '0;
               end
            end
            ST_DATA: begin
               if (enc_acc) begin
                  if (line_cnt == data_lim - LINE_W'(1)) begin
                     if (data_lim == LINE_W'(DATA_LINES)) begin
                        line_cnt <= '0;
                        st       <= ST_PARITY_IN;
                     end else begin
                        line_cnt <= line_cnt + LINE_W'(1);
                        st       <= ST_PAD;
                     end
                  end else begin
                     line_cnt <= line_cnt + LINE_W'(1);
                  end
               end
            end
            ST_PAD: begin
               if (enc_acc) begin
                  if (line_cnt == LINE_W'(DATA_LINES - 1)) begin
                     line_cnt <= '0;
                     st       <= ST_PARITY_IN;
                  end else begin
                     line_cnt <= line_cnt + LINE_W'(1);
                  end
               end
            end
            ST_PARITY_IN: begin
               if (enc_acc) begin
                  if (mode == DEFERRED)
                     wr_addr <= wr_addr + 1'b1;
                  if (par_last) begin
                     par_cnt <= '0;
                     if (!blk_last) begin
                        blk_cnt <= blk_cnt + BLK_W'(1);
                        st      <= ST_DATA;
                     end else if (mode == INTERLEAVE) begin
                        st <= ST_READY;
                     end else begin
                        st <= ST_DRAIN;
                     end
                  end else begin
                     par_cnt <= par_cnt + PAR_W'(1);
                  end
               end
            end
            ST_DRAIN: begin
               if (rd_en)
                  rd_addr <= rd_addr + 1'b1;
               if (drain_end)
                  st <= ST_READY;
            end
            default: st <= ST_READY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sk_wp       <= 1'b0;
         sk_rp       <= 1'b0;
         sk_cnt      <= 2'd0;
         rd_inflight <= 1'b0;
      end else begin
         rd_inflight <= rd_en;
         if (push)
            sk_wp <= ~sk_wp;
         if (sk_pop)
            sk_rp <= ~sk_rp;
         sk_cnt <= sk_cnt + {1'b0, push} - {1'b0, sk_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         sk_mem[sk_wp] <= rd_data;
   end

   rs_parity_buf #(
      .DEPTH (DEPTH),
      .WIDTH (DATA_W),
      .AW    (ADDR_W)
   ) u_pbuf (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_addr[ADDR_W-1:0]),
      .wr_data (enc_data),
      .rd_en   (rd_en),
      .rd_addr (rd_addr[ADDR_W-1:0]),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_rs_encode_multimode_out_ctrl.sv
// Scoreboard bench for the RS encoder output controller.
// Expected lines are queued as the encoder is driven.
module tb_rs_encode_multimode_out_ctrl;

   localparam int DW = 256;

   logic          clk;
   logic          rst;
   logic          req_val;
   logic          req_rdy;
   logic [4:0]    req_num_blocks;
   logic [3:0]    req_last_data_lines;
   logic          req_interleave;
   logic          enc_val;
   logic          enc_rdy;
   logic [DW-1:0] enc_data;
   logic          out_val;
   logic          out_rdy;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          busy;

   rs_encode_multimode_out_ctrl dut (
      .clk                 (clk),
      .rst                 (rst),
      .req_val             (req_val),
      .req_rdy             (req_rdy),
      .req_num_blocks      (req_num_blocks),
      .req_last_data_lines (req_last_data_lines),
      .req_interleave      (req_interleave),
      .enc_val             (enc_val),
      .enc_rdy             (enc_rdy),
      .enc_data            (enc_data),
      .out_val             (out_val),
      .out_rdy             (out_rdy),
      .out_data            (out_data),
      .out_last            (out_last),
      .busy                (busy)
   );

   typedef struct {
      logic [DW-1:0] d;
      logic          last;
      logic          drain;
   } exp_t;

   exp_t q[$];
   exp_t par[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   rdy_mode = 0;
   int   drain_cnt = 0;
   int   first_drain = 0;
   int   last_drain = 0;
   int   last_acc = 0;
   int   n_out = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string tag, logic [DW-1:0] got,
                        logic [DW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] mk(int tag, int blk, int kind,
                                        int idx);
      logic [31:0] w;
      w = {8'(tag), 8'(blk), 8'(kind), 8'(idx)};
      return {8{w}};
   endfunction

   initial begin
      out_rdy = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0: out_rdy = 1'b1;
            1: out_rdy = ~out_rdy;
            default: out_rdy = 1'($urandom_range(0, 1));
         endcase
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst && out_val) begin
            if (out_rdy) begin
               check("avail", q.size() > 0, 1);
               if (q.size() > 0) begin
                  e = q.pop_front();
                  check("data", out_data, e.d);
                  check("last", out_last, e.last);
                  if (e.drain) begin
                     if (drain_cnt == 0) first_drain = cyc;
                     last_drain = cyc;
                     drain_cnt++;
                  end
                  n_out++;
               end
            end else if (q.size() > 0) begin
               check("hold", out_data, q[0].d);
            end
         end
      end
   end

   task automatic send_req(int nb, int ldl, bit il);
      int t;
      assert (nb >= 1 && nb <= 16 && ldl >= 1 && ldl <= 8)
         else $error("illegal request meta");
      @(posedge clk);
      #1;
      req_val = 1'b1;
      req_num_blocks = 5'(nb);
      req_last_data_lines = 4'(ldl);
      req_interleave = il;
      t = 0;
      @(negedge clk);
      while (!req_rdy && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("req_acc", req_rdy, 1);
      @(posedge clk);
      #1;
      req_val = 1'b0;
   endtask

   task automatic drive_line(logic [DW-1:0] d);
      int t;
      enc_val = 1'b1;
      enc_data = d;
      t = 0;
      @(negedge clk);
      while (!enc_rdy && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("enc_acc", enc_rdy, 1);
      last_acc = cyc;
      @(posedge clk);
      #1;
      enc_val = 1'b0;
   endtask

   task automatic start(int tag, int nb, int ldl, bit il);
      logic [DW-1:0] d;
      exp_t e;
      drain_cnt = 0;
      par.delete();
      send_req(nb, ldl, il);
      for (int b = 0; b < nb; b++) begin
         for (int i = 0; i < 8; i++) begin
            if (b < nb - 1 || i < ldl) begin
               d = mk(tag, b, 1, i);
               e = '{d: d, last: 1'b0, drain: 1'b0};
               q.push_back(e);
            end else begin
               d = mk(tag, b, 2, i);
            end
            drive_line(d);
         end
         for (int j = 0; j < 2; j++) begin
            d = mk(tag, b, 3, j);
            e = '{d: d, last: (b == nb - 1 && j == 1), drain: !il};
            if (il) q.push_back(e);
            else par.push_back(e);
            drive_line(d);
         end
      end
      while (par.size() > 0) q.push_back(par.pop_front());
   endtask

   task automatic finish_req(int nb, int ldl, int out0);
      int t;
      t = 0;
      while (q.size() > 0 && t < 1000) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("drained", q.size(), 0);
      check("count", n_out - out0, (nb - 1) * 8 + ldl + 2 * nb);
      check("idle_rdy", req_rdy, 1);
      check("idle_busy", busy, 0);
   endtask

   task automatic run(int tag, int nb, int ldl, bit il);
      int o;
      o = n_out;
      start(tag, nb, ldl, il);
      finish_req(nb, ldl, o);
   endtask

   initial begin
      int t;
      rst = 1'b0;
      req_val = 1'b0;
      req_num_blocks = '0;
      req_last_data_lines = '0;
      req_interleave = 1'b0;
      enc_val = 1'b0;
      enc_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_rdy", req_rdy, 1);
      check("rst_enc_rdy", enc_rdy, 0);
      check("rst_out_val", out_val, 0);
      check("rst_out_last", out_last, 0);
      check("rst_busy", busy, 0);
      rst = 1'b1;

      rdy_mode = 0;
      run(1, 3, 8, 1'b1);

      run(2, 4, 5, 1'b0);
      check("drain_n", drain_cnt, 8);
      check("drain_rate", last_drain - first_drain, 7);
      check("drain_lat", first_drain - last_acc, 2);

      rdy_mode = 1;
      run(3, 4, 8, 1'b0);
      check("drain_n_tog", drain_cnt, 8);

      rdy_mode = 0;
      run(4, 1, 1, 1'b1);

      rdy_mode = 2;
      run(5, 5, 3, 1'b0);
      run(6, 2, 6, 1'b1);

      rdy_mode = 1;
      start(7, 4, 8, 1'b0);
      t = 0;
      while (drain_cnt < 3 && t < 200) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("pre_rst_drain", drain_cnt >= 3, 1);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("mid_rst_out_val", out_val, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_req_rdy", req_rdy, 1);
      rst = 1'b1;
      q.delete();
      rdy_mode = 0;
      run(8, 1, 4, 1'b0);
      check("post_rst_drain", drain_cnt, 2);

      run(9, 16, 3, 1'b0);
      check("max_drain_n", drain_cnt, 32);
      check("max_drain_rate", last_drain - first_drain, 31);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout exp finish");
      $fatal(1, "watchdog");
   end

endmodule
